ysyx_22050612_mem_responder: RTL

YSYX_22050612_MEM_RESPONDER -- requirements
Module: ysyx_22050612_mem_responder

---
 rtl/ysyx_22050612_mem_pkg.sv | 26 ++
 rtl/ysyx_22050612_mem_array.sv | 30 +++
 rtl/ysyx_22050612_mem_responder.sv | 112 +++++++++++
 3 files changed

// File: rtl/ysyx_22050612_mem_pkg.sv
// Shared types and constants for the single-outstanding memory responder.
// Holds the FSM state encoding, default base address and latency counter width.
package ysyx_22050612_mem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [63:0] DefaultBase = 64'h8000_0000;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int unsigned CntWidth = 4;

  // Turn an 8-bit byte-lane enable into a 64-bit bit mask.
  function automatic logic [63:0] expand_mask(input logic [7:0] mask);
    logic [63:0] bits;
    bits = '0;
    for (int b = 0; b < 8; b++) begin
      bits[8*b +: 8] = {8{mask[b]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/ysyx_22050612_mem_array.sv
// 2^DEPTH_LOG2 x 64-bit word storage: synchronous byte-masked write, combinational read.
// Contents are deliberately not reset.
module ysyx_22050612_mem_array
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [63:0]           wdata_i,
  input  logic [7:0]            wmask_i,
  output logic [63:0]           rdata_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [63:0] mem_q [Depth];
  logic [63:0] bit_mask;

  assign bit_mask = expand_mask(wmask_i);
  assign rdata_o  = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~bit_mask) | (wdata_i & bit_mask);
    end
  end

endmodule

// File: rtl/ysyx_22050612_mem_responder.sv
// Fixed-latency memory responder: accepts one request at a time, performs the access at
// accept, then presents the response LATENCY cycles later until the initiator takes it.
module ysyx_22050612_mem_responder
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2,
  parameter logic [63:0] BASE       = DefaultBase
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [CntWidth-1:0] LatLoad  = CntWidth'(LATENCY - 1);
  localparam logic [63:0]         SpanSize = 64'd8 << DEPTH_LOG2;

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [63:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 in_range;
  logic [63:0]          offset;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [63:0]          arr_rdata;

  // Unsigned compare against BASE first so addresses below it never wrap into range.
  assign offset   = req_addr - BASE;
  assign in_range = (req_addr >= BASE) && (offset < SpanSize);
  assign word_idx = offset[DEPTH_LOG2+2:3];

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  ysyx_22050612_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem_array (
    .clk_i  (clk),
    .we_i   (accept && req_wen && in_range),
    .addr_i (word_idx),
    .wdata_i(req_wdata),
    .wmask_i(req_wmask),
    .rdata_o(arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = LatLoad;
          err_d   = !in_range;
          rdata_d = (in_range && !req_wen) ? arr_rdata : '0;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        rdata_d = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
